// File: rtl/acorn_pad_sequencer.sv
// ACORN-128 input sequencer: streams W-step words of data || 1 || 0^255 with ca/cb
// flags for one associated-data or message phase.
module acorn_pad_sequencer #(
    parameter int unsigned W     = 8,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     m_out,
    output logic             ca_out,
    output logic             cb_out,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done
);

    localparam int unsigned TAIL  = 256 / W;
    localparam int unsigned CAHI  = 128 / W;
    // Shared data/pad counter: must hold len without wrapping and reach TAIL-1 (<= 255).
    localparam int unsigned CNT_W = (LEN_W + 1 > 9) ? LEN_W + 1 : 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               mode_q;
    logic [LEN_W-1:0]   len_q;
    logic [W-1:0]       m_q;
    logic               ca_q;
    logic               cb_q;
    logic               last_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic               load_en;

    assign cnt_d    = cnt_q + CNT_W'(1);
    assign load_en  = !valid_q || out_ready;
    assign in_ready = (state_q == S_DATA) && load_en;

    assign m_out     = m_q;
    assign ca_out    = ca_q;
    assign cb_out    = cb_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Phase FSM and the one-deep output word register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            len_q   <= '0;
            m_q     <= '0;
            ca_q    <= 1'b0;
            cb_q    <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        len_q   <= len;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (len == '0) ? S_PAD : S_DATA;
                    end
                end
                S_DATA: begin
                    if (load_en) begin
                        if (in_valid) begin
                            m_q     <= in_data;
                            ca_q    <= 1'b1;
                            cb_q    <= mode_q;
                            last_q  <= 1'b0;
                            valid_q <= 1'b1;
                            if (cnt_d == CNT_W'(len_q)) begin
                                cnt_q   <= '0;
                                state_q <= S_PAD;
                            end else begin
                                cnt_q <= cnt_d;
                            end
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    // Word t of the tail: the single padding 1 lands in step 0 of t==0.
                    if (load_en) begin
                        m_q     <= (cnt_q == '0) ? W'(1) : '0;
                        ca_q    <= (cnt_q < CNT_W'(CAHI));
                        cb_q    <= mode_q;
                        last_q  <= (cnt_q == CNT_W'(TAIL - 1));
                        valid_q <= 1'b1;
                        if (cnt_q == CNT_W'(TAIL - 1)) begin
                            cnt_q   <= '0;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                S_DONE: begin
                    // Final word is held until consumed; done and busy-drop share the next cycle.
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acorn_pad_sequencer.sv
// Randomized bench for acorn_pad_sequencer: W=8 (full scenarios), W=1 and W=128 (len=1),
// checked against a step-level model of the data || 1 || 0^255 stream.
module tb_acorn_pad_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // W=8 instance
    logic        a_start = 0, a_mode = 0, a_busy, a_in_valid = 0, a_in_ready;
    logic [15:0] a_len = 0;
    logic [7:0]  a_in_data = 0, a_m;
    logic        a_ca, a_cb, a_last, a_ov, a_or = 0, a_done;
    // W=1 instance
    logic        b_start = 0, b_mode = 0, b_busy, b_in_valid = 0, b_in_ready;
    logic [15:0] b_len = 0;
    logic [0:0]  b_in_data = 0, b_m;
    logic        b_ca, b_cb, b_last, b_ov, b_or = 0, b_done;
    // W=128 instance
    logic         c_start = 0, c_mode = 0, c_busy, c_in_valid = 0, c_in_ready;
    logic [15:0]  c_len = 0;
    logic [127:0] c_in_data = 0, c_m;
    logic         c_ca, c_cb, c_last, c_ov, c_or = 0, c_done;

    acorn_pad_sequencer #(.W(8), .LEN_W(16)) u_w8 (
        .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .len(a_len), .busy(a_busy),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .m_out(a_m), .ca_out(a_ca), .cb_out(a_cb), .out_last(a_last),
        .out_valid(a_ov), .out_ready(a_or), .done(a_done));

    acorn_pad_sequencer #(.W(1), .LEN_W(16)) u_w1 (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .len(b_len), .busy(b_busy),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .m_out(b_m), .ca_out(b_ca), .cb_out(b_cb), .out_last(b_last),
        .out_valid(b_ov), .out_ready(b_or), .done(b_done));

    acorn_pad_sequencer #(.W(128), .LEN_W(16)) u_w128 (
        .clk(clk), .rst(rst), .start(c_start), .mode(c_mode), .len(c_len), .busy(c_busy),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .m_out(c_m), .ca_out(c_ca), .cb_out(c_cb), .out_last(c_last),
        .out_valid(c_ov), .out_ready(c_or), .done(c_done));

    logic [7:0] dq[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bits of word k in the stream data(n*w bits) || 1 || 0^255.
    function automatic logic [127:0] exp_word(int w, int n, int k, logic [127:0] dat);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (k * w + i < n * w) r[i] = dat[i];
            else if (k * w + i == n * w) r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic fill(input int n);
        dq.delete();
        for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
    endtask

    task automatic run8(input int n, input bit md, input int stall, input int start_at, input int abort_at);
        int k, di, cyc, ins;
        bit hold, pulsed, aborted;
        logic [11:0]  prev;
        logic [127:0] ew;
        logic [127:0] dat;
        k = 0; di = 0; cyc = 0; ins = 0; hold = 0; pulsed = 0; aborted = 0; prev = '0;
        @(negedge clk);
        a_start = 1; a_mode = md; a_len = 16'(n); a_in_valid = 0; a_or = 0;
        @(negedge clk);
        a_start = 0; a_mode = ~md; a_len = 16'($urandom);
        #1 check("busy_after_start", 128'(a_busy), 128'(1));
        while (k < n + 32 && cyc < 3000) begin
            a_in_valid = (di < n) && ($urandom_range(99) >= stall);
            a_in_data  = (di < n) ? dq[di] : 8'($urandom);
            a_or       = ($urandom_range(99) >= stall);
            a_start    = 0;
            if (start_at >= 0 && k == start_at && !pulsed) begin
                a_start = 1; a_mode = ~md; a_len = 16'($urandom_range(1, 5)); pulsed = 1;
            end
            #1;
            if (hold) check("stall_hold", 128'({a_m, a_ca, a_cb, a_last, a_ov}), 128'(prev));
            prev = {a_m, a_ca, a_cb, a_last, a_ov};
            hold = a_ov && !a_or;
            if (a_in_ready) ins++;
            if (a_ov && a_or) begin
                dat = (k < n) ? 128'(dq[k]) : '0;
                ew  = exp_word(8, n, k, dat);
                check("word8", 128'({a_m, a_ca, a_cb, a_last}),
                      128'({ew[7:0], (k * 8 < n * 8 + 128), md, (k == n + 31)}));
                k++;
            end
            if (a_in_valid && a_in_ready) di++;
            if (abort_at >= 0 && k == abort_at) aborted = 1;
            @(negedge clk);
            cyc++;
            if (aborted) break;
        end
        a_start = 0; a_in_valid = 0;
        if (aborted) begin
            rst = 0;
            #1 check("abort_zero", 128'({a_ov, a_busy, a_in_ready, a_done, a_m, a_ca, a_cb, a_last}), '0);
            @(negedge clk);
            rst = 1;
            return;
        end
        check("word_count", 128'(k), 128'(n + 32));
        if (n == 0) check("in_ready_len0", 128'(ins), 128'(0));
        a_or = 0;
        #1 check("done_busy", 128'({a_done, a_busy, a_ov}), 128'(3'b100));
        @(negedge clk);
        #1 check("done_pulse", 128'(a_done), 128'(0));
    endtask

    task automatic run_w1();
        int words, casteps, padpos, cyc;
        bit md, fin;
        logic d;
        logic [127:0] ew;
        md = 1'($urandom); d = 1'($urandom);
        words = 0; casteps = 0; padpos = -1; cyc = 0; fin = 0;
        @(negedge clk);
        b_start = 1; b_mode = md; b_len = 16'd1; b_in_data = d; b_in_valid = 1; b_or = 1;
        @(negedge clk);
        b_start = 0;
        while (!fin && cyc < 1000) begin
            #1;
            if (b_ov) begin
                ew = exp_word(1, 1, words, 128'(d));
                check("word1", 128'({b_m, b_ca, b_cb, b_last}),
                      128'({ew[0], (words < 129), md, (words == 256)}));
                if (b_ca) casteps += 1;
                if (b_m[0] && words >= 1 && padpos < 0) padpos = words;
                if (b_last) fin = 1;
                words++;
            end
            @(negedge clk);
            cyc++;
        end
        b_in_valid = 0;
        check("w1_words", 128'(words), 128'(257));
        check("w1_ca_steps", 128'(casteps), 128'(129));
        check("w1_pad_pos", 128'(padpos), 128'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic run_w128();
        int words, casteps, padpos, cyc;
        bit md, fin;
        logic [127:0] d;
        logic [127:0] ew;
        md = 1'($urandom);
        d = {$urandom, $urandom, $urandom, $urandom};
        words = 0; casteps = 0; padpos = -1; cyc = 0; fin = 0;
        @(negedge clk);
        c_start = 1; c_mode = md; c_len = 16'd1; c_in_data = d; c_in_valid = 1; c_or = 1;
        @(negedge clk);
        c_start = 0;
        while (!fin && cyc < 100) begin
            #1;
            if (c_ov) begin
                ew = exp_word(128, 1, words, d);
                check("word128", {c_m}, ew);
                check("flags128", 128'({c_ca, c_cb, c_last}),
                      128'({(words * 128 < 256), md, (words == 2)}));
                if (c_ca) casteps += 128;
                for (int i = 0; i < 128; i++)
                    if (c_m[i] && words * 128 + i >= 128 && padpos < 0) padpos = words * 128 + i;
                if (c_last) fin = 1;
                words++;
            end
            @(negedge clk);
            cyc++;
        end
        c_in_valid = 0;
        check("w128_words", 128'(words), 128'(3));
        check("w128_ca_steps", 128'(casteps), 128'(256));
        check("w128_pad_pos", 128'(padpos), 128'(128));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2 rst = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_w8", 128'({a_ov, a_busy, a_in_ready, a_done, a_m, a_ca, a_cb, a_last}), '0);
        check("rst_w1", 128'({b_ov, b_busy, b_in_ready, b_done, b_m, b_ca, b_cb, b_last}), '0);
        check("rst_w128", {c_ov, c_busy, c_in_ready, c_done, c_ca, c_cb, c_last} == '0 ? c_m : ~c_m, '0);
        @(negedge clk);
        rst = 1;

        dq.delete(); dq.push_back(8'hA5); dq.push_back(8'h3C);
        run8(2, 1, 0, -1, -1);
        fill(0);
        run8(0, 0, 0, -1, -1);
        fill(3);
        run8(3, 1, 40, -1, -1);
        fill(3);
        run8(3, 0, 40, -1, -1);
        fill(2);
        run8(2, 0, 20, 7, -1);
        fill(1);
        run8(1, 1, 0, -1, -1);
        fill(4);
        run8(4, 1, 0, -1, 10);
        fill(4);
        run8(4, 0, 30, -1, -1);
        for (int i = 0; i < 4; i++) begin
            int n;
            n = $urandom_range(0, 6);
            fill(n);
            run8(n, 1'($urandom), $urandom_range(0, 50), -1, -1);
        end
        run_w1();
        run_w128();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
